// File: rtl/image_ram_arbiter.sv
// Shares the single image RAM port between the feature-fetch engine (A) and the
// writeback/debug path (B), with bounded round-robin bursts and read routing.
module image_ram_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int BE_W         = 4,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              a_req,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [DATA_W-1:0] a_writedata,
  input  logic [BE_W-1:0]   a_byteenable,
  output logic              a_grant,
  output logic              a_readdatavalid,
  output logic [DATA_W-1:0] a_readdata,
  input  logic              b_req,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [DATA_W-1:0] b_writedata,
  input  logic [BE_W-1:0]   b_byteenable,
  output logic              b_grant,
  output logic              b_readdatavalid,
  output logic [DATA_W-1:0] b_readdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_clken,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic [BE_W-1:0]   ram_byteenable,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic              busy
);
  // Handshake: a requester holds req and its command fields stable; the
  // command is taken at the rising edge where req & grant are both high.

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} owner_t;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  owner_t           owner_q, owner_d;
  logic             rr_b_q, rr_b_d;   // 1: B wins the next tie from idle
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant_a, grant_b;
  logic             rd_accept;
  logic [READ_LATENCY:0] pipe_vld, pipe_id;  // id 1 = requester B

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      owner_q <= OWN_NONE;
      rr_b_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      owner_q <= owner_d;
      rr_b_q  <= rr_b_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    owner_d = owner_q;
    rr_b_d  = rr_b_q;
    cnt_d   = cnt_q;
    if (!grant_a && !grant_b) begin
      owner_d = OWN_NONE;
      cnt_d   = '0;
    end else begin
      if (owner_q == OWN_NONE && a_req && b_req) rr_b_d = grant_a;
      if ((grant_a && owner_q == OWN_A) || (grant_b && owner_q == OWN_B)) begin
        if (cnt_q < MAX_CNT) cnt_d = cnt_q + ONE;
      end else begin
        owner_d = grant_a ? OWN_A : OWN_B;
        cnt_d   = ONE;
      end
    end
  end

  // Grants are forced low while reset is asserted so every output reads 0.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (reset_reset_n) begin
      if (a_req && !b_req) grant_a = 1'b1;
      else if (b_req && !a_req) grant_b = 1'b1;
      else if (a_req && b_req) begin
        unique case (owner_q)
          OWN_A:   if (cnt_q < MAX_CNT) grant_a = 1'b1; else grant_b = 1'b1;
          OWN_B:   if (cnt_q < MAX_CNT) grant_b = 1'b1; else grant_a = 1'b1;
          default: if (rr_b_q) grant_b = 1'b1; else grant_a = 1'b1;
        endcase
      end
    end
  end

  assign a_grant   = grant_a;
  assign b_grant   = grant_b;
  assign rd_accept = (grant_a && !a_write) || (grant_b && !b_write);
  assign busy      = (owner_q != OWN_NONE) || (|pipe_vld);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      ram_clken      <= 1'b0;
      ram_chipselect <= 1'b0;
      ram_write      <= 1'b0;
      ram_address    <= '0;
      ram_writedata  <= '0;
      ram_byteenable <= '0;
    end else begin
      ram_clken      <= 1'b1;
      ram_chipselect <= grant_a || grant_b;
      ram_write      <= (grant_a && a_write) || (grant_b && b_write);
      if (grant_a) begin
        ram_address    <= a_address;
        ram_writedata  <= a_writedata;
        ram_byteenable <= a_byteenable;
      end else if (grant_b) begin
        ram_address    <= b_address;
        ram_writedata  <= b_writedata;
        ram_byteenable <= b_byteenable;
      end
    end
  end

  // The last pipe stage lines up with the cycle ram_readdata is valid.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pipe_vld        <= '0;
      pipe_id         <= '0;
      a_readdatavalid <= 1'b0;
      b_readdatavalid <= 1'b0;
      a_readdata      <= '0;
      b_readdata      <= '0;
    end else begin
      pipe_vld        <= {pipe_vld[READ_LATENCY-1:0], rd_accept};
      pipe_id         <= {pipe_id[READ_LATENCY-1:0], grant_b};
      a_readdatavalid <= pipe_vld[READ_LATENCY] && !pipe_id[READ_LATENCY];
      b_readdatavalid <= pipe_vld[READ_LATENCY] && pipe_id[READ_LATENCY];
      if (pipe_vld[READ_LATENCY] && !pipe_id[READ_LATENCY]) a_readdata <= ram_readdata;
      if (pipe_vld[READ_LATENCY] && pipe_id[READ_LATENCY])  b_readdata <= ram_readdata;
    end
  end
endmodule

// File: doc/image_ram_arbiter.md
Name: image_ram_arbiter

Overview:
Two-requester arbiter for the exported on-chip image RAM port (10-bit word address, 32-bit data, byte enables, chipselect/clken/write).
- Requester A is the accelerator feature-fetch engine.
- Requester B is the result-writeback / debug path.
- The block shares the single RAM port between them with round-robin arbitration and bounded bursts.
- It tracks RAM read latency and routes each read response back to the requester that issued it.

Parameters:
ADDR_W, 10, RAM word address width
DATA_W, 32, data width
BE_W, 4, byte-enable width (DATA_W/8)
READ_LATENCY, 1, cycles from RAM command to valid ram_readdata (1 or 2)
MAX_BURST, 4, max consecutive accepted beats per owner while the other requester waits (1..15)

Ports:
clk_clk  in  1  clock
reset_reset_n  in  1  asynchronous active-low reset
a_req  in  1  A command request
a_write  in  1  A: 1=write, 0=read
a_address  in  ADDR_W  A word address
a_writedata  in  DATA_W  A write data
a_byteenable  in  BE_W  A byte enables
a_grant  out  1  A command accepted this cycle (req & grant)
a_readdatavalid  out  1  A read data valid
a_readdata  out  DATA_W  A read data
b_req, b_write, b_address, b_writedata, b_byteenable  in  as A  requester B command
b_grant, b_readdatavalid, b_readdata  out  as A  requester B responses
ram_address  out  ADDR_W  RAM address
ram_chipselect  out  1  RAM command valid
ram_clken  out  1  RAM clock enable
ram_write  out  1  RAM write strobe
ram_writedata  out  DATA_W  RAM write data
ram_byteenable  out  BE_W  RAM byte enables
ram_readdata  in  DATA_W  RAM read data
busy  out  1  reads in flight or owner active

Behaviour:
- Reset values: all outputs 0, including ram_clken. Arbitration state: owner=NONE, rr_next=A, beat counter=0, in-flight pipe empty.
- ram_clken is registered and goes to 1 on the first clock edge after reset release, then stays 1.
- Grant logic:
  - a_grant/b_grant are combinational from req and registered state.
  - At most one grant is high per cycle.
  - A command is accepted at a clock edge where req & grant.
- Arbitration rules, evaluated each cycle:
  - owner=X, X requesting, other requesting, count<MAX_BURST: grant X.
  - owner=X, count==MAX_BURST, other requesting: grant the other; owner:=other; count:=1.
  - Only one requester active: grant it; count saturates at MAX_BURST.
  - Neither requesting: owner:=NONE; count:=0.
  - Both request with owner=NONE: rr_next wins; rr_next:=loser.
- Command path:
  - The accepted command is registered onto ram_* in the next cycle, with ram_chipselect=1 and ram_write=req_write.
  - In idle cycles: ram_chipselect=0, ram_write=0; address, data and byte enables hold their last values.
  - Full throughput: one command per cycle.
- Read tracking:
  - A shift pipe of depth READ_LATENCY+1 carries {valid, port id} for each accepted read.
  - ram_readdata is sampled READ_LATENCY cycles after the command cycle.
  - The sample is registered to x_readdata, with x_readdatavalid pulsed for one cycle.
  - Read latency is accept cycle + 2 + READ_LATENCY (3 for default).
  - Responses are returned in issue order. Both readdatavalid outputs are never high in the same cycle.
  - Writes produce no response.
- Read data on the non-selected port holds its previous value.
- busy = owner≠NONE or any in-flight pipe entry valid.
- Simultaneous A and B first requests after reset: A wins.
- Requester dropping req mid-burst: rotation is allowed immediately.
- Reset mid-operation:
  - All in-flight reads are discarded.
  - No readdatavalid is produced after release.
  - Outputs go to 0 immediately (asynchronous).

Test Plan:
1. A read addr 0x010, RAM model returns 0xDEADBEEF:
   - a_grant=1 in the request cycle.
   - Next cycle: ram_chipselect=1, ram_address=0x010, ram_write=0.
   - a_readdatavalid=1 with 0xDEADBEEF 3 cycles after accept; b_readdatavalid stays 0.
2. B write addr 0x3FF, data 0x12345678, be 0x3:
   - Next cycle: ram_write=1, ram_address=0x3FF, ram_byteenable=0x3.
   - No readdatavalid on either port.
3. a_req and b_req both held high from reset, MAX_BURST=4:
   - Grant sequence is A,A,A,A,B,B,B,B,A,…
   - Never both grants in one cycle.
4. A issues 4 back-to-back reads, addr 0..3, RAM returns addr+0x100:
   - a_readdatavalid high 4 consecutive cycles, data 0x100..0x103 in order.
5. Reset pulsed low with 2 reads in flight:
   - All outputs 0 immediately.
   - No readdatavalid after release.
   - ram_clken=1 one edge after release.
6. READ_LATENCY=2, B read addr 0x005:
   - b_readdatavalid exactly 4 cycles after accept.
